// File: rtl/timestamp_extractor_if.sv
// AXI-Stream bundle for the timestamp extractor.
// Ports: tdata/tvalid/tlast from master, tready from slave.
interface timestamp_extractor_if #(
    parameter int DATA_WIDTH = 256
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/timestamp_extractor.sv
// Measures packet latency from an embedded stamp while passing the stream through.
// Ports: axi_aclk/axi_resetn, s_axis/m_axis streams, stamp_counter, enable,
// clear_stats, latency/latency_valid, min/max_latency, pkt_count, err_count.
module timestamp_extractor #(
    parameter int C_S_AXIS_DATA_WIDTH = 256,
    parameter int TIMESTAMP_WIDTH     = 64,
    parameter int TS_WORD             = 1,
    parameter int TS_OFFSET           = 0
) (
    input  logic                       axi_aclk,
    input  logic                       axi_resetn,
    timestamp_extractor_if.slave       s_axis,
    timestamp_extractor_if.master      m_axis,
    input  logic [TIMESTAMP_WIDTH-1:0] stamp_counter,
    input  logic                       enable,
    input  logic                       clear_stats,
    output logic [TIMESTAMP_WIDTH-1:0] latency,
    output logic                       latency_valid,
    output logic [TIMESTAMP_WIDTH-1:0] min_latency,
    output logic [TIMESTAMP_WIDTH-1:0] max_latency,
    output logic [31:0]                pkt_count,
    output logic [31:0]                err_count
);

    // Counter must hold TS_WORD+1 without wrapping.
    localparam int CNT_W = $clog2(TS_WORD + 2);
    localparam logic [CNT_W-1:0] TS_IDX = CNT_W'(TS_WORD);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_TS,
        WAIT_LAST,
        SKIP
    } state_t;

    state_t                     state, state_nxt;
    logic [CNT_W-1:0]           cnt, cnt_nxt;
    logic [TIMESTAMP_WIDTH-1:0] stamp_q, stamp_nxt;
    logic [TIMESTAMP_WIDTH-1:0] meas_stamp;
    logic [TIMESTAMP_WIDTH-1:0] ts_field;
    logic [TIMESTAMP_WIDTH-1:0] lat_new;
    logic                       beat;
    logic                       meas;
    logic                       err;

    assign m_axis.tdata  = s_axis.tdata;
    assign m_axis.tvalid = s_axis.tvalid;
    assign m_axis.tlast  = s_axis.tlast;
    assign s_axis.tready = m_axis.tready;

    assign beat     = s_axis.tvalid & m_axis.tready;
    assign ts_field = s_axis.tdata[TS_OFFSET +: TIMESTAMP_WIDTH];
    assign lat_new  = stamp_counter - meas_stamp;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        stamp_nxt  = stamp_q;
        meas_stamp = stamp_q;
        meas       = 1'b0;
        err        = 1'b0;
        if (beat) begin
            unique case (state)
                IDLE: begin
                    if (!enable) begin
                        state_nxt = s_axis.tlast ? IDLE : SKIP;
                    end else if (TS_WORD == 0) begin
                        if (s_axis.tlast) begin
                            meas       = 1'b1;
                            meas_stamp = ts_field;
                        end else begin
                            stamp_nxt = ts_field;
                            state_nxt = WAIT_LAST;
                        end
                    end else if (s_axis.tlast) begin
                        // Packet ended before the stamp beat.
                        err = 1'b1;
                    end else begin
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = WAIT_TS;
                    end
                end
                WAIT_TS: begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt == TS_IDX) begin
                        if (s_axis.tlast) begin
                            // Stamp and end share a beat: use it directly.
                            meas       = 1'b1;
                            meas_stamp = ts_field;
                            state_nxt  = IDLE;
                        end else begin
                            stamp_nxt = ts_field;
                            state_nxt = WAIT_LAST;
                        end
                    end else if (s_axis.tlast) begin
                        err       = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                WAIT_LAST: begin
                    if (s_axis.tlast) begin
                        meas      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                SKIP: begin
                    if (s_axis.tlast) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state   <= IDLE;
            cnt     <= '0;
            stamp_q <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            stamp_q <= stamp_nxt;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            latency       <= '0;
            latency_valid <= 1'b0;
            min_latency   <= '1;
            max_latency   <= '0;
            pkt_count     <= '0;
            err_count     <= '0;
        end else begin
            latency_valid <= meas;
            if (meas) begin
                latency <= lat_new;
            end
            // Clear wins over any same-cycle measurement or error.
            if (clear_stats) begin
                min_latency <= '1;
                max_latency <= '0;
                pkt_count   <= '0;
                err_count   <= '0;
            end else begin
                if (meas) begin
                    if (pkt_count != 32'hFFFF_FFFF) begin
                        pkt_count <= pkt_count + 32'd1;
                    end
                    if (lat_new < min_latency) begin
                        min_latency <= lat_new;
                    end
                    if (lat_new > max_latency) begin
                        max_latency <= lat_new;
                    end
                end
                if (err && err_count != 32'hFFFF_FFFF) begin
                    err_count <= err_count + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_timestamp_extractor.sv
// Scoreboard bench for timestamp_extractor (TS_WORD=1, TS_OFFSET=0).
// Ports: drives both stream interfaces and the measurement controls.
module tb_timestamp_extractor;

    logic        clk;
    logic        rst_n;
    logic [63:0] stamp_counter;
    logic        enable;
    logic        clear_stats;
    logic [63:0] latency;
    logic        latency_valid;
    logic [63:0] min_latency;
    logic [63:0] max_latency;
    logic [31:0] pkt_count;
    logic [31:0] err_count;

    timestamp_extractor_if #(.DATA_WIDTH(256)) s_if ();
    timestamp_extractor_if #(.DATA_WIDTH(256)) m_if ();

    timestamp_extractor #(
        .C_S_AXIS_DATA_WIDTH(256),
        .TIMESTAMP_WIDTH    (64),
        .TS_WORD            (1),
        .TS_OFFSET          (0)
    ) dut (
        .axi_aclk     (clk),
        .axi_resetn   (rst_n),
        .s_axis       (s_if),
        .m_axis       (m_if),
        .stamp_counter(stamp_counter),
        .enable       (enable),
        .clear_stats  (clear_stats),
        .latency      (latency),
        .latency_valid(latency_valid),
        .min_latency  (min_latency),
        .max_latency  (max_latency),
        .pkt_count    (pkt_count),
        .err_count    (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [63:0] exp_q[$];
    logic [63:0] m_min;
    logic [63:0] m_max;
    logic [31:0] m_pkt;
    logic [31:0] m_errc;

    task automatic check(input string tag, input logic [255:0] obs,
                         input logic [255:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        m_min  = '1;
        m_max  = '0;
        m_pkt  = '0;
        m_errc = '0;
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_pkt"}, 256'(pkt_count), 256'(m_pkt));
        check({tag, "_err"}, 256'(err_count), 256'(m_errc));
        check({tag, "_min"}, 256'(min_latency), 256'(m_min));
        check({tag, "_max"}, 256'(max_latency), 256'(m_max));
    endtask

    // Scoreboard consumer: every latency pulse must match a queued result.
    always @(negedge clk) begin
        if (rst_n && latency_valid) begin
            if (exp_q.size() == 0) begin
                check("lv_spurious", 256'(1), 256'(0));
            end else begin
                check("latency", 256'(latency), 256'(exp_q.pop_front()));
            end
        end
    end

    task automatic check_pt(input logic [255:0] d, input logic last,
                            input logic rdy);
        check("pt_data", m_if.tdata, d);
        check("pt_valid", 256'(m_if.tvalid), 256'(1));
        check("pt_last", 256'(m_if.tlast), 256'(last));
        check("pt_ready", 256'(s_if.tready), 256'(rdy));
    endtask

    task automatic send_pkt(input int nb, input logic [63:0] stamp,
                            input logic [63:0] sc_last, input bit en,
                            input bit stall, input bit clr);
        logic [255:0] d;
        logic [63:0]  lat;
        logic         last;
        for (int i = 0; i < nb; i++) begin
            last = (i == nb - 1);
            d = rand256();
            if (i == 1) d[63:0] = stamp;
            s_if.tdata    = d;
            s_if.tvalid   = 1'b1;
            s_if.tlast    = last;
            enable        = (i == 0) ? en : !en;
            stamp_counter = last ? sc_last : {$urandom, $urandom};
            if (stall) begin
                m_if.tready = 1'b0;
                #1;
                check_pt(d, last, 1'b0);
                @(posedge clk);
                #1;
            end
            m_if.tready = 1'b1;
            clear_stats = clr && last;
            if (last && en) begin
                lat = sc_last - stamp;
                if (nb >= 2) exp_q.push_back(lat);
                if (clr) begin
                    model_reset();
                end else if (nb >= 2) begin
                    m_pkt = m_pkt + 1;
                    if (lat < m_min) m_min = lat;
                    if (lat > m_max) m_max = lat;
                end else begin
                    m_errc = m_errc + 1;
                end
            end else if (last && clr) begin
                model_reset();
            end
            #1;
            check_pt(d, last, 1'b1);
            @(posedge clk);
            #1;
        end
        clear_stats = 1'b0;
    endtask

    task automatic idle(input int n);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        check("q_drain", 256'(exp_q.size()), 256'(0));
    endtask

    task automatic clr_pulse();
        clear_stats = 1'b1;
        @(posedge clk);
        #1;
        clear_stats = 1'b0;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n         = 1'b0;
        s_if.tdata    = '0;
        s_if.tvalid   = 1'b0;
        s_if.tlast    = 1'b0;
        m_if.tready   = 1'b1;
        stamp_counter = '0;
        enable        = 1'b0;
        clear_stats   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_lat", 256'(latency), 256'(0));
        check("rst_lv", 256'(latency_valid), 256'(0));
        check_stats("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic 3-beat measurement: 0x164 - 0x100
        send_pkt(3, 64'h100, 64'h164, 1'b1, 1'b0, 1'b0);
        idle(3);
        check_stats("v1");

        // Back-to-back packets after a clear
        clr_pulse();
        send_pkt(3, 64'h1000, 64'h1020, 1'b1, 1'b0, 1'b0);
        send_pkt(4, 64'h2000, 64'h2010, 1'b1, 1'b0, 1'b0);
        idle(3);
        check_stats("v2");

        // Short packet: ends before the stamp beat
        clr_pulse();
        send_pkt(1, 64'h0, 64'h55, 1'b1, 1'b0, 1'b0);
        idle(3);
        check_stats("v3");

        // Wrapping subtraction
        send_pkt(3, 64'hFFFF_FFFF_FFFF_FFF0, 64'h10, 1'b1, 1'b0, 1'b0);
        idle(3);
        check_stats("v4");

        // Stamp beat is also the last beat
        send_pkt(2, 64'h500, 64'h577, 1'b1, 1'b1, 1'b0);
        idle(3);
        check_stats("stamp_last");

        // Disabled at first beat, enable toggles later, with stalls
        send_pkt(3, 64'h700, 64'h7FF, 1'b0, 1'b1, 1'b0);
        idle(3);
        check_stats("v5");

        // Clear coincident with a measurement
        send_pkt(3, 64'h1000, 64'h1030, 1'b1, 1'b0, 1'b1);
        idle(3);
        check_stats("v6");
        check("v6_lat", 256'(latency), 256'(64'h30));

        // Reset in the middle of a packet
        s_if.tdata  = rand256();
        s_if.tvalid = 1'b1;
        s_if.tlast  = 1'b0;
        enable      = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_lat", 256'(latency), 256'(0));
        check_stats("mid_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_pkt(3, 64'h40, 64'h4A, 1'b1, 1'b0, 1'b0);
        idle(3);
        check_stats("post_rst");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/timestamp_extractor.md
TIMESTAMP_EXTRACTOR -- requirements
Module: timestamp_extractor

Interface
REQ-001 Parameter C_S_AXIS_DATA_WIDTH, default 256: AXI-Stream data width in bits.
REQ-002 Parameter TIMESTAMP_WIDTH, default 64: embedded-stamp and local-counter width in bits.
REQ-003 Parameter TS_WORD, default 1: zero-based beat index carrying the embedded stamp.
REQ-004 Parameter TS_OFFSET, default 0: bit offset of stamp LSB within beat; multiple of 8; TS_OFFSET+TIMESTAMP_WIDTH <= C_S_AXIS_DATA_WIDTH.
REQ-005 axi_aclk  in  1  sole clock; all logic on rising edge.
REQ-006 axi_resetn  in  1  asynchronous, active-low reset.
REQ-007 s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  input packet data.
REQ-008 s_axis_tvalid, s_axis_tlast  in  1 each  AXI-Stream valid / end-of-packet.
REQ-009 s_axis_tready  out  1  equals m_axis_tready combinationally.
REQ-010 m_axis_tdata, m_axis_tvalid, m_axis_tlast  out  as inputs  combinational pass-through of s_axis.
REQ-011 m_axis_tready  in  1  downstream ready.
REQ-012 stamp_counter  in  TIMESTAMP_WIDTH  local free-running time, same clock domain.
REQ-013 enable  in  1  measurement enable.
REQ-014 clear_stats  in  1  synchronous statistics clear pulse.
REQ-015 latency  out  TIMESTAMP_WIDTH  last measured latency.
REQ-016 latency_valid  out  1  one-cycle pulse when latency updates.
REQ-017 min_latency, max_latency  out  TIMESTAMP_WIDTH each  running extremes.
REQ-018 pkt_count, err_count  out  32 each  measured packets / short-packet errors.

Function
REQ-019 Beat = cycle with s_axis_tvalid & m_axis_tready; only beats advance state.
REQ-020 FSM states: IDLE, WAIT_TS, WAIT_LAST, SKIP.
REQ-021 IDLE, first beat: enable=0 -> SKIP (or stay IDLE if tlast); enable=1 and TS_WORD=0 -> capture stamp, WAIT_LAST (or measure if tlast); else beat counter=1, WAIT_TS.
REQ-022 WAIT_TS: each beat increments beat counter; beat with index TS_WORD captures tdata[TS_OFFSET+:TIMESTAMP_WIDTH] -> WAIT_LAST; tlast before TS_WORD -> err_count+1, IDLE, no measurement.
REQ-023 Stamp beat carrying tlast: measure using that beat's stamp directly, -> IDLE.
REQ-024 WAIT_LAST: tlast beat -> measure, IDLE. SKIP: tlast beat -> IDLE.
REQ-025 enable sampled only at first beat; later changes ignored for that packet.
REQ-026 Measure: latency <= stamp_counter (value at tlast beat) - stamp, modulo 2^TIMESTAMP_WIDTH; latency and latency_valid update cycle after tlast beat.
REQ-027 On measure: pkt_count+1; min_latency <= min(min,latency); max_latency <= max(max,latency); compares use new latency value, unsigned.
REQ-028 pkt_count and err_count saturate at 32'hFFFFFFFF.
REQ-029 clear_stats: next cycle min_latency=all ones, max_latency=0, pkt_count=0, err_count=0; a measurement/error in the same cycle is discarded from stats (latency output still updates).
REQ-030 Pass-through path has zero latency, never alters data, never stalls independently.
REQ-031 Back-to-back packets (tlast then next first beat in consecutive cycles) handled without loss.

Reset
REQ-032 axi_resetn low: FSM=IDLE, beat counter=0, captured stamp=0, latency=0, latency_valid=0, min_latency=all ones, max_latency=0, pkt_count=0, err_count=0.
REQ-033 Reset mid-packet: remainder of that packet after release treated as new packet from its next beat.

Verification
V-1 enable=1, TS_WORD=1, 3-beat packet, stamp 0x100, stamp_counter 0x164 at tlast -> latency 0x64, one latency_valid pulse, pkt_count 1, min=max=0x64.
V-2 Two packets latencies 0x20 then 0x10 -> min 0x10, max 0x20, pkt_count 2.
V-3 1-beat packet, TS_WORD=1 -> err_count 1, no latency_valid, pkt_count 0.
V-4 stamp 0xFFFFFFFF_FFFFFFF0, stamp_counter 0x10 -> latency 0x20 (wrap).
V-5 enable=0 at first beat, set 1 mid-packet -> no measurement; m_axis mirrors s_axis each beat incl. tready stalls.
V-6 clear_stats coincident with measure of 0x30 -> latency 0x30, pkt_count 0, min all ones, max 0.
